// File: rtl/ahb_sram_slv.sv
// AHB-Lite slave front end for a single-port synchronous SRAM (32-bit data).
// Define AHB_SRAM_ERR_RESP_EN for a two-cycle ERROR response to illegal transfers.
module ahb_sram_slv #(
    parameter int SRAM_AW = 14
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hsel,
    input  logic               hwrite,
    input  logic               hready,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic [2:0]         hburst,
    input  logic [31:0]        haddr,
    input  logic [31:0]        hwdata,
    output logic               hready_resp,
    output logic [1:0]         hresp,
    output logic [31:0]        hrdata,
    output logic               sram_csn,
    output logic [3:0]         sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RPEND, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RPEND} state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRAM_AW-1:0] r_waddr;
    logic [SRAM_AW-1:0] w_waddr_nxt;
    logic [SRAM_AW-1:0] r_raddr;
    logic [SRAM_AW-1:0] w_raddr_nxt;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [SRAM_AW-1:0] w_word;
    logic [3:0]         r_wlanes;
    logic [3:0]         w_wlanes_nxt;
    logic [3:0]         w_lanes;
    logic [31:0]        r_sram_wdata;
    logic               r_rvalid;
    logic               w_rvalid_nxt;
    logic               w_acc;
    logic               w_legal;
    logic               w_open;
    logic               w_unused;

    assign w_unused = ^{hburst, htrans[0]};
    // Gated by reset so a held address phase cannot touch the SRAM in reset
    assign w_acc    = hresetn & hsel & hready & htrans[1];
    assign w_word   = haddr[SRAM_AW+1:2];
    assign hrdata   = r_rvalid ? sram_rdata : 32'h0;

    always_comb begin
        w_legal = (hsize <= 3'd2) && (haddr[31:SRAM_AW+2] == '0);
        w_lanes = 4'b1111;
        case (hsize)
            3'd0: w_lanes = 4'b0001 << haddr[1:0];
            3'd1: begin
                w_lanes = haddr[1] ? 4'b1100 : 4'b0011;
                if (haddr[0])
                    w_legal = 1'b0;
            end
            3'd2: begin
                if (haddr[1:0] != 2'b00)
                    w_legal = 1'b0;
            end
            default: w_lanes = 4'b1111;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_waddr_nxt  = r_waddr;
        w_wlanes_nxt = r_wlanes;
        w_raddr_nxt  = r_raddr;
        w_rvalid_nxt = 1'b0;
        w_open       = 1'b1;
        hready_resp  = 1'b1;
        hresp        = 2'b00;
        sram_csn     = 1'b1;
        sram_wen     = 4'hF;
        sram_addr    = r_sram_addr;
        sram_wdata   = r_sram_wdata;
        case (r_state)
            S_WDATA: begin
                sram_csn    = 1'b0;
                sram_wen    = ~r_wlanes;
                sram_addr   = r_waddr;
                sram_wdata  = hwdata;
                w_state_nxt = S_IDLE;
            end
            S_RPEND: begin
                hready_resp  = 1'b0;
                sram_csn     = 1'b0;
                sram_addr    = r_raddr;
                w_rvalid_nxt = 1'b1;
                w_open       = 1'b0;
                w_state_nxt  = S_IDLE;
            end
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1: begin
                hready_resp = 1'b0;
                hresp       = 2'b01;
                w_open      = 1'b0;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                hresp       = 2'b01;
                w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_open && w_acc && w_legal) begin
            if (hwrite) begin
                w_waddr_nxt  = w_word;
                w_wlanes_nxt = w_lanes;
                w_state_nxt  = S_WDATA;
            end else if (r_state == S_WDATA) begin
                // SRAM port is busy with the write; replay the read next cycle
                w_raddr_nxt = w_word;
                w_state_nxt = S_RPEND;
            end else begin
                sram_csn     = 1'b0;
                sram_addr    = w_word;
                w_rvalid_nxt = 1'b1;
            end
        end
`ifdef AHB_SRAM_ERR_RESP_EN
        if (w_open && w_acc && !w_legal)
            w_state_nxt = S_ERR1;
`endif
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state      <= S_IDLE;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_wlanes     <= '0;
            r_rvalid     <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_waddr      <= w_waddr_nxt;
            r_raddr      <= w_raddr_nxt;
            r_wlanes     <= w_wlanes_nxt;
            r_rvalid     <= w_rvalid_nxt;
            r_sram_addr  <= sram_addr;
            r_sram_wdata <= sram_wdata;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Bench for ahb_sram_slv: AHB master driver, SRAM model, reference memory
// and a per-cycle data-phase checker, plus directed literal expectations.
module tb_ahb_sram_slv;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_BAD  = 3;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic        hwrite;
    logic        hready;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        sram_csn;
    logic [3:0]  sram_wen;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int n_pass  = 0;
    int n_total = 0;

    assign hready = hready_resp;

    ahb_sram_slv #(.SRAM_AW(14)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .hwrite      (hwrite),
        .hready      (hready),
        .htrans      (htrans),
        .hsize       (hsize),
        .hburst      (hburst),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hready_resp (hready_resp),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .sram_csn    (sram_csn),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // SRAM device: synchronous, read data one cycle after the read
    bit [31:0] sram_mem [16384];
    always @(posedge hclk) begin
        if (!sram_csn) begin
            if (sram_wen == 4'hF)
                sram_rdata <= sram_mem[sram_addr];
            else
                for (int i = 0; i < 4; i++)
                    if (!sram_wen[i])
                        sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    // Reference model: what each AHB data phase must look like
    bit [31:0]   ref_mem [16384];
    int          dp_kind   = K_NONE;
    int          snap_kind = K_NONE;
    int          k         = 0;
    logic [31:0] dp_addr   = 0;
    logic [31:0] snap_addr = 0;
    logic [3:0]  dp_mask   = 0;
    logic [3:0]  snap_mask = 0;
    bit          prev_wr   = 0;
    bit          last_rdy  = 1;

    always @(negedge hclk) begin
        int nb;
        int m;
        int waits;
        bit ok;
        if (!hresetn) begin
            chk("rst_ready", {31'h0, hready_resp}, 32'h1);
            chk("rst_resp", {30'h0, hresp}, 32'h0);
            chk("rst_rdata", hrdata, 32'h0);
            chk("rst_csn", {31'h0, sram_csn}, 32'h1);
            chk("rst_wen", {28'h0, sram_wen}, 32'hF);
            dp_kind   = K_NONE;
            snap_kind = K_NONE;
            prev_wr   = 0;
            last_rdy  = 1;
            k         = 0;
        end else begin
            if (last_rdy) begin
                prev_wr = (dp_kind == K_WR);
                dp_kind = snap_kind;
                dp_addr = snap_addr;
                dp_mask = snap_mask;
                k       = 0;
            end else begin
                k++;
            end
            case (dp_kind)
                K_WR: begin
                    chk("wr_ready", {31'h0, hready_resp}, 32'h1);
                    chk("wr_resp", {30'h0, hresp}, 32'h0);
                    chk("wr_csn", {31'h0, sram_csn}, 32'h0);
                    chk("wr_wen", {28'h0, sram_wen}, {28'h0, ~dp_mask});
                    chk("wr_addr", {18'h0, sram_addr}, dp_addr >> 2);
                    chk("wr_wdata", sram_wdata, hwdata);
                    for (int i = 0; i < 4; i++)
                        if (dp_mask[i])
                            ref_mem[dp_addr[15:2]][8*i +: 8] = hwdata[8*i +: 8];
                end
                K_RD: begin
                    waits = prev_wr ? 1 : 0;
                    if (k < waits) begin
                        chk("rpend_ready", {31'h0, hready_resp}, 32'h0);
                        chk("rpend_csn", {31'h0, sram_csn}, 32'h0);
                        chk("rpend_wen", {28'h0, sram_wen}, 32'hF);
                        chk("rpend_addr", {18'h0, sram_addr}, dp_addr >> 2);
                    end else begin
                        chk("rd_ready", {31'h0, hready_resp}, 32'h1);
                        chk("rd_resp", {30'h0, hresp}, 32'h0);
                        chk("rd_data", hrdata, ref_mem[dp_addr[15:2]]);
                    end
                end
                K_BAD: begin
`ifdef AHB_SRAM_ERR_RESP_EN
                    if (k == 0) begin
                        chk("err1_ready", {31'h0, hready_resp}, 32'h0);
                        chk("err1_resp", {30'h0, hresp}, 32'h1);
                        chk("err1_csn", {31'h0, sram_csn}, 32'h1);
                    end else begin
                        chk("err2_ready", {31'h0, hready_resp}, 32'h1);
                        chk("err2_resp", {30'h0, hresp}, 32'h1);
                        chk("err2_rdata", hrdata, 32'h0);
                    end
`else
                    chk("bad_ready", {31'h0, hready_resp}, 32'h1);
                    chk("bad_resp", {30'h0, hresp}, 32'h0);
                    chk("bad_rdata", hrdata, 32'h0);
                    chk("bad_wen", {28'h0, sram_wen}, 32'hF);
`endif
                end
                default: begin
                    chk("idle_ready", {31'h0, hready_resp}, 32'h1);
                    chk("idle_resp", {30'h0, hresp}, 32'h0);
                    chk("idle_rdata", hrdata, 32'h0);
                end
            endcase
            last_rdy = hready_resp;
            snap_kind = K_NONE;
            if (hsel && htrans[1]) begin
                nb = (hsize <= 3'd2) ? (1 << hsize) : 1;
                ok = (hsize <= 3'd2) && (haddr % nb == 0) && (haddr < 32'h10000);
                m  = ((1 << nb) - 1) << (haddr % 4);
                snap_addr = haddr;
                snap_mask = m[3:0];
                snap_kind = !ok ? K_BAD : (hwrite ? K_WR : K_RD);
            end
        end
    end

    // Master driver: one address phase per call, hwdata trails by one beat
    logic [31:0] pend_wd   = 0;
    logic [31:0] cap_rdata = 0;
    logic [3:0]  cap_wen   = 0;
    logic [1:0]  cap_resp  = 0;
    int          cap_waits = 0;

    task automatic issue(input bit act, input bit w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        bit rdy;
        hsel   = act;
        htrans = act ? 2'b10 : 2'b00;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = pend_wd;
        cap_waits = 0;
        n = 0;
        do begin
            @(negedge hclk);
            rdy       = hready_resp;
            cap_rdata = hrdata;
            cap_resp  = hresp;
            cap_wen   = sram_wen;
            if (!rdy)
                cap_waits++;
            @(posedge hclk);
            #1;
            n++;
        end while (!rdy && n < 20);
        chk("handshake", {31'h0, rdy}, 32'h1);
        pend_wd = wd;
    endtask

    task automatic idle();
        issue(0, 0, 3'd0, 32'h0, 32'h0);
    endtask

    logic [31:0] bad_a [4] = '{32'h2, 32'h1, 32'h10000, 32'h0};
    logic [2:0]  bad_s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        hresetn = 0;
        hsel = 0;
        htrans = 0;
        hwrite = 0;
        hsize = 0;
        hburst = 0;
        haddr = 0;
        hwdata = 0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_addr", {18'h0, sram_addr}, 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        hresetn = 1;

        issue(1, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        idle();
        chk("t1_wen", {28'h0, cap_wen}, 32'h0);
        issue(1, 0, 3'd2, 32'h10, 32'h0);
        idle();
        chk("t1_rdata", cap_rdata, 32'hDEADBEEF);
        chk("t1_waits", cap_waits, 0);

        issue(1, 1, 3'd2, 32'h10, 32'h11223344);
        issue(1, 1, 3'd0, 32'h13, 32'hAA000000);
        idle();
        chk("t2_wen", {28'h0, cap_wen}, 32'h7);
        issue(1, 0, 3'd2, 32'h10, 32'h0);
        idle();
        chk("t2_rdata", cap_rdata, 32'hAA223344);

        issue(1, 1, 3'd2, 32'h20, 32'h5A5A5A5A);
        issue(1, 0, 3'd2, 32'h20, 32'h0);
        idle();
        chk("t3_waits", cap_waits, 1);
        chk("t3_rdata", cap_rdata, 32'h5A5A5A5A);

        issue(1, 1, 3'd1, 32'h22, 32'hBEEF0000);
        issue(1, 0, 3'd2, 32'h20, 32'h0);
        idle();
        chk("t3h_waits", cap_waits, 1);
        chk("t3h_rdata", cap_rdata, 32'hBEEF5A5A);

        for (int i = 0; i < 4; i++) begin
            issue(1, 0, bad_s[i], bad_a[i], 32'h0);
            idle();
`ifdef AHB_SRAM_ERR_RESP_EN
            chk("t4_waits", cap_waits, 1);
            chk("t4_resp", {30'h0, cap_resp}, 32'h1);
`else
            chk("t5_waits", cap_waits, 0);
            chk("t5_resp", {30'h0, cap_resp}, 32'h0);
`endif
            chk("t4_rdata", cap_rdata, 32'h0);
        end
        issue(1, 1, 3'd2, 32'h12, 32'hFFFFFFFF);
        idle();
        issue(1, 0, 3'd2, 32'h10, 32'h0);
        idle();
        chk("t5_nowrite", cap_rdata, 32'hAA223344);

        issue(1, 1, 3'd2, 32'h40, 32'h01020304);
        idle();
        issue(1, 1, 3'd2, 32'h40, 32'hCAFEF00D);
        hwdata = 32'hCAFEF00D;
        hsel   = 0;
        htrans = 2'b00;
        #2;
        hresetn = 0;
        #1;
        chk("t6_csn", {31'h0, sram_csn}, 32'h1);
        chk("t6_ready", {31'h0, hready_resp}, 32'h1);
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1;
        pend_wd = 0;
        issue(1, 0, 3'd2, 32'h40, 32'h0);
        idle();
        chk("t6_rdata", cap_rdata, 32'h01020304);

        idle();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
